// File: rtl/vliw_fetch_if.sv
// Instruction-memory channel between the fetch stage (master) and imem (slave):
// a valid/ready request carrying a bundle address, and an in-order response.
interface vliw_fetch_if #(
  parameter int SLOTS = 4
);
  logic                req_valid;
  logic                req_ready;
  logic [31:0]         req_addr;
  logic                resp_valid;
  logic [32*SLOTS-1:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/vliw_fetch.sv
// VLIW fetch stage: holds the bundle PC, issues credit-limited in-order fetches,
// buffers responses in a show-ahead FIFO and flushes the wrong path on redirect.
module vliw_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          SLOTS      = 4,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  vliw_fetch_if.master        imem,
  output logic                bundle_valid,
  output logic [32*SLOTS-1:0] bundle,
  output logic [31:0]         bundle_pc
);
  localparam int               BW         = 32 * SLOTS;
  localparam int               ALIGN_BITS = $clog2(4 * SLOTS);
  localparam logic [31:0]      ALIGN_MASK = ~((32'd1 << ALIGN_BITS) - 32'd1);
  localparam logic [31:0]      STRIDE     = 32'(4 * SLOTS);
  localparam int               PTR_W      = $clog2(FIFO_DEPTH);
  localparam int               CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(FIFO_DEPTH);

  logic [31:0]      fetch_pc_reg;
  logic [CNT_W-1:0] outstanding_reg;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic [CNT_W-1:0] occ_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] pcq_rd_reg;
  logic [PTR_W-1:0] pcq_wr_reg;

  // Bundle buffer (data + pc) and the PCs of requests still in flight.
  logic [BW-1:0]    fifo_data_mem [FIFO_DEPTH];
  logic [31:0]      fifo_pc_mem   [FIFO_DEPTH];
  logic [31:0]      pcq_mem       [FIFO_DEPTH];

  logic             pop;
  logic             push;
  logic             req_ok;
  logic             req_fire;
  logic             resp_drop;
  logic [CNT_W:0]   credit_used;
  logic [CNT_W-1:0] resp_dec;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check counts in-flight requests (including ones that will be dropped)
  // plus buffered bundles, so every response is guaranteed a free slot.
  always_comb begin
    bundle_valid = (occ_reg != '0);
    pop          = bundle_valid && !stall;
    credit_used  = {1'b0, outstanding_reg} + {1'b0, occ_reg} - {{CNT_W{1'b0}}, pop};
    req_ok       = rst && !redirect && (credit_used < DEPTH_C);
    req_fire     = req_ok && imem.req_ready;
    resp_drop    = (drop_cnt_reg != '0);
    push         = imem.resp_valid && !resp_drop && !redirect;
    resp_dec     = {{(CNT_W-1){1'b0}}, imem.resp_valid};
  end

  assign imem.req_valid = req_ok;
  assign imem.req_addr  = fetch_pc_reg;

  // Control state: PC, credit counters, pointers; redirect flushes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_reg    <= RESET_PC & ALIGN_MASK;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      occ_reg         <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      pcq_rd_reg      <= '0;
      pcq_wr_reg      <= '0;
    end else if (redirect) begin
      // Every request still unanswered after this cycle belongs to the wrong path.
      fetch_pc_reg    <= redirect_pc & ALIGN_MASK;
      outstanding_reg <= outstanding_reg - resp_dec;
      drop_cnt_reg    <= outstanding_reg - resp_dec;
      occ_reg         <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      pcq_rd_reg      <= '0;
      pcq_wr_reg      <= '0;
    end else begin
      outstanding_reg <= outstanding_reg + CNT_W'(req_fire) - resp_dec;
      occ_reg         <= occ_reg + CNT_W'(push) - CNT_W'(pop);
      if (req_fire) begin
        fetch_pc_reg <= fetch_pc_reg + STRIDE;
        pcq_wr_reg   <= ptr_inc(pcq_wr_reg);
      end
      if (imem.resp_valid && resp_drop) begin
        drop_cnt_reg <= drop_cnt_reg - CNT_W'(1);
      end
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        pcq_rd_reg <= ptr_inc(pcq_rd_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
    end
  end

  // Storage writes: PC of each accepted request, and response data paired with its PC.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq_mem[pcq_wr_reg] <= fetch_pc_reg;
    end
    if (push) begin
      fifo_data_mem[wr_ptr_reg] <= imem.resp_data;
      fifo_pc_mem[wr_ptr_reg]   <= pcq_mem[pcq_rd_reg];
    end
  end

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign bundle[32*gi +: 32] = bundle_valid ? fifo_data_mem[rd_ptr_reg][32*gi +: 32] : NOP_INST;
    end
  endgenerate

  assign bundle_pc = bundle_valid ? fifo_pc_mem[rd_ptr_reg] : 32'h0;

  // Responses must answer an accepted request and must never meet a full buffer.
  a_resp_has_req: assert property (@(posedge clk) disable iff (!rst)
    imem.resp_valid |-> (outstanding_reg != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    push |-> (occ_reg != FULL_C));
endmodule

// File: tb/tb_vliw_fetch.sv
// Directed bench for vliw_fetch: a small in-order memory model with variable
// latency/ready, a fetch-PC model and an expected bundle-stream model.
module tb_vliw_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          SLOTS  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         stall = 1'b0;
  logic         redirect = 1'b0;
  logic [31:0]  redirect_pc = 32'h0;
  logic         bundle_valid;
  logic [127:0] bundle;
  logic [31:0]  bundle_pc;

  vliw_fetch_if #(.SLOTS(SLOTS)) imem_bus ();

  vliw_fetch #(
    .RESET_PC   (RST_PC),
    .SLOTS      (SLOTS),
    .FIFO_DEPTH (2),
    .NOP_INST   (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem         (imem_bus),
    .bundle_valid (bundle_valid),
    .bundle       (bundle),
    .bundle_pc    (bundle_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Memory returns slot i = addr + 4*i, so slot 0 equals the bundle address.
  function automatic logic [127:0] mkdata(input logic [31:0] a);
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  logic [31:0]  mq_addr [$];
  int           mq_due  [$];
  int           lat = 1;
  bit           ready_en = 1'b1;
  int           cyc = 0;
  logic [31:0]  model_pc = RST_PC;
  logic [31:0]  exp_pc   = RST_PC;

  logic         obs_valid;
  logic         obs_req_valid;
  logic [31:0]  obs_req_addr;
  logic [31:0]  obs_pc;
  logic [127:0] obs_bundle;

  // One clock cycle: drive inputs, sample outputs mid-cycle, update models.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    bit hs;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_bus.req_ready = ready_en;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_bus.resp_valid = 1'b1;
      imem_bus.resp_data  = mkdata(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_bus.resp_valid = 1'b0;
      imem_bus.resp_data  = '0;
    end
    #1;
    obs_valid     = bundle_valid;
    obs_req_valid = imem_bus.req_valid;
    obs_req_addr  = imem_bus.req_addr;
    obs_pc        = bundle_pc;
    obs_bundle    = bundle;
    hs = obs_req_valid && ready_en;
    if (obs_req_valid) check("req_addr", obs_req_addr, model_pc);
    if (!rd && obs_valid) begin
      check("bundle_pc", obs_pc, exp_pc);
      check("bundle", obs_bundle, mkdata(exp_pc));
      if (!st) exp_pc += 32'd16;
    end
    if (hs) begin
      mq_addr.push_back(obs_req_addr);
      mq_due.push_back(cyc + lat);
      model_pc += 32'd16;
    end
    if (rd) begin
      model_pc = rpc & ~32'hF;
      exp_pc   = rpc & ~32'hF;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    imem_bus.req_ready  = 1'b1;
    imem_bus.resp_valid = 1'b0;
    imem_bus.resp_data  = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_valid", bundle_valid, 1'b0);
    check("rst_pc", bundle_pc, 32'h0);
    check("rst_bundle", bundle, {4{NOP}});
    check("rst_req_valid", imem_bus.req_valid, 1'b0);

    // Reset release and sustained streaming
    rst = 1'b1;
    step(0, 0, 0);
    check("first_req_valid", obs_req_valid, 1'b1);
    check("first_req_addr", obs_req_addr, RST_PC);
    step(0, 0, 0);
    check("fill_valid", obs_valid, 1'b0);
    step(0, 0, 0);
    check("first_pc", obs_pc, 32'h100);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0);
      check("stream_valid", obs_valid, 1'b1);
    end

    // Memory not ready for 5 cycles: request held at the same address
    ready_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      check("hold_req_valid", obs_req_valid, 1'b1);
    end
    ready_en = 1'b1;
    for (int i = 0; i < 6; i++) step(0, 0, 0);

    // Stall: buffer fills, then 4 cycles frozen with no requests
    for (int i = 0; i < 2; i++) step(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      check("stall_req_valid", obs_req_valid, 1'b0);
      check("stall_valid", obs_valid, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      check("resume_valid", obs_valid, 1'b1);
    end

    // 3-cycle memory, redirect with two requests in flight
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq_due.size() == 2 && mq_due[0] > cyc) found = 1'b1;
      else step(0, 0, 0);
    end
    check("two_outstanding", found, 1'b1);
    step(0, 1, 32'h2004);
    check("redir_req_valid", obs_req_valid, 1'b0);
    step(0, 0, 0);
    check("flush_valid", obs_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0);
      if (obs_valid) begin
        found = 1'b1;
        check("first_target_pc", obs_pc, 32'h2000);
      end
    end
    check("target_arrived", found, 1'b1);
    for (int i = 0; i < 6; i++) step(0, 0, 0);

    // Address wrap at the top of the address space
    lat = 1;
    step(0, 1, 32'hFFFF_FFE0);
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0);
      if (obs_valid && obs_pc == 32'h0) found = 1'b1;
    end
    check("wrap_seen", found, 1'b1);

    // Redirect (during stall) in the same cycle as a response
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mq_due.size() > 0 && mq_due[0] <= cyc) found = 1'b1;
      else step(0, 0, 0);
    end
    check("resp_in_redirect", found, 1'b1);
    step(1, 1, 32'h3000);
    step(0, 0, 0);
    check("r1_valid", obs_valid, 1'b0);
    check("r1_req_valid", obs_req_valid, 1'b1);
    check("r1_req_addr", obs_req_addr, 32'h3000);
    step(0, 0, 0);
    check("r2_valid", obs_valid, 1'b0);
    step(0, 0, 0);
    check("r3_valid", obs_valid, 1'b1);
    check("r3_pc", obs_pc, 32'h3000);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // Asynchronous reset with two requests in flight
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq_due.size() == 2) found = 1'b1;
      else step(0, 0, 0);
    end
    check("rst_two_outstanding", found, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", bundle_valid, 1'b0);
    check("mid_rst_pc", bundle_pc, 32'h0);
    check("mid_rst_bundle", bundle, {4{NOP}});
    check("mid_rst_req_valid", imem_bus.req_valid, 1'b0);
    mq_addr.delete();
    mq_due.delete();
    model_pc = RST_PC;
    exp_pc   = RST_PC;
    lat = 1;
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0);
      check("in_rst_req_valid", obs_req_valid, 1'b0);
    end
    rst = 1'b1;
    step(0, 0, 0);
    check("rerun_req_valid", obs_req_valid, 1'b1);
    check("rerun_req_addr", obs_req_addr, RST_PC);
    step(0, 0, 0);
    step(0, 0, 0);
    check("rerun_valid", obs_valid, 1'b1);
    check("rerun_pc", obs_pc, RST_PC);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
